// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, update-FSM state encoding and sync polarity helper.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int FRAME_W = 8;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_VBL = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } upd_state_t;

  // Map an active-high sync indication onto the configured pin level.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping counter with combinational wrap pulse and
// registered sync/visible flags decoded from the next count value.
module vga_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int VISIBLE    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int W          = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync,
  output logic         visible
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END  = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_LO  = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_END = W'(SYNC_START + SYNC_LEN);

  logic [W-1:0] count_nxt;

  // Next count; wrap is combinational so the next axis steps on the same edge.
  always_comb begin
    wrap      = step && (count == LAST);
    count_nxt = count;
    if (step) begin
      count_nxt = wrap ? '0 : count + 1'b1;
    end
  end

  // Count register plus flags decoded from the next value (zero skew to count).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      sync    <= 1'b0;
      visible <= 1'b1;
    end else begin
      count   <= count_nxt;
      sync    <= (count_nxt >= SYNC_LO) && (count_nxt < SYNC_END);
      visible <= (count_nxt < VIS_END);
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA timing controller: pixel divider, h/v scan counters, sync decode,
// frame counter and a vblank-gated update-window arbiter for game logic.
module vga_frame_sequencer
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_tick,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  input  logic               upd_req,
  output logic               upd_grant,
  input  logic               upd_done,
  output logic               upd_overrun
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             h_wrap, v_wrap;
  logic             h_sync_act, v_sync_act;
  logic             h_vis, v_vis;
  logic             vblank;
  upd_state_t       state, state_nxt;
  logic             set_overrun;

  assign pix_tick = (div == DIV_LAST);

  // Pixel clock divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .W          (CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .step    (pix_tick),
    .count   (h_count),
    .wrap    (h_wrap),
    .sync    (h_sync_act),
    .visible (h_vis)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .W          (CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .step    (h_wrap),
    .count   (v_count),
    .wrap    (v_wrap),
    .sync    (v_sync_act),
    .visible (v_vis)
  );

  assign hsync    = sync_level(h_sync_act, SYNC_POL);
  assign vsync    = sync_level(v_sync_act, SYNC_POL);
  assign video_on = h_vis && v_vis;
  assign vblank   = ~v_vis;

  // Frame pulse and counter, asserted on the edge that lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= v_wrap;
      if (v_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Update arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Update arbiter next state; upd_done wins over a simultaneous vblank end.
  always_comb begin
    state_nxt   = state;
    set_overrun = 1'b0;
    case (state)
      ST_IDLE: begin
        if (upd_req) state_nxt = ST_WAIT_VBL;
      end
      ST_WAIT_VBL: begin
        if (!upd_req)    state_nxt = ST_IDLE;
        else if (vblank) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (upd_done) begin
          state_nxt = ST_RELEASE;
        end else if (v_wrap) begin
          state_nxt   = ST_WAIT_VBL;
          set_overrun = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!upd_req) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign upd_grant = (state == ST_GRANT);

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_overrun <= 1'b0;
    end else if (set_overrun) begin
      upd_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer using a reduced raster
// (24 x 13 positions, CLK_DIV=4) so whole frames stay short.
module tb_vga_frame_sequencer;
  import vga_timing_pkg::*;

  localparam int CD  = 4;
  localparam int HV  = 16, HFP = 2, HS = 4, HBP = 2;  // H_TOTAL 24, hsync h 18..21
  localparam int VV  = 8,  VFP = 1, VS = 2, VBP = 2;  // V_TOTAL 13, vsync v 9..10
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int FRAME_CLKS = CD * HT * VT;           // 1248

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_tick;
  logic [9:0] h_count, v_count;
  logic       hsync, vsync, video_on, frame_start;
  logic [7:0] frame_cnt;
  logic       upd_req = 1'b0;
  logic       upd_grant;
  logic       upd_done = 1'b0;
  logic       upd_overrun;

  int checks = 0;
  int failures = 0;

  vga_frame_sequencer #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .h_count(h_count),
    .v_count(v_count), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .upd_req(upd_req),
    .upd_grant(upd_grant), .upd_done(upd_done), .upd_overrun(upd_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;     // posedges since reset release
    int h;
    int v;
    bit hs;
    bit vs;
    bit von;
    bit tick;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    upd_req = 1'b0;
    upd_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_v(input int target, input int budget, input string nm);
    int k = 0;
    while (v_count != 10'(target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(v_count), 32'(target));
  endtask

  initial begin
    int cur;
    int bad;
    int pulses;
    int k;

    // n, h, v, hsync, vsync, video_on, pix_tick
    tbl[0]  = '{0,    0,  0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{3,    0,  0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{4,    1,  0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{39,   9,  0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{40,   10, 0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{71,   17, 0,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{72,   18, 0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{87,   21, 0,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{88,   22, 0,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{95,   23, 0,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{96,   0,  1,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{864,  0,  9,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1056, 0,  11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1248, 0,  0,  1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_h", 32'(h_count), 0);
    chk("rst_v", 32'(v_count), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_video_on", 32'(video_on), 1);
    chk("rst_tick", 32'(pix_tick), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_grant", 32'(upd_grant), 0);
    chk("rst_overrun", 32'(upd_overrun), 0);
    reset = 1'b0;

    // Table vectors through the first frame.
    cur = 0;
    for (int i = 0; i < 14; i++) begin
      repeat (tbl[i].n - cur) @(negedge clk);
      cur = tbl[i].n;
      chk($sformatf("vec%0d_h", i), 32'(h_count), 32'(tbl[i].h));
      chk($sformatf("vec%0d_v", i), 32'(v_count), 32'(tbl[i].v));
      chk($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(tbl[i].vs));
      chk($sformatf("vec%0d_video_on", i), 32'(video_on), 32'(tbl[i].von));
      chk($sformatf("vec%0d_tick", i), 32'(pix_tick), 32'(tbl[i].tick));
    end
    chk("frame_start_at_wrap", 32'(frame_start), 1);
    chk("frame_cnt_after_frame", 32'(frame_cnt), 1);
    @(negedge clk);
    chk("frame_start_one_clk", 32'(frame_start), 0);

    // Cycle-by-cycle sweep of one full frame against a position model.
    do_reset();
    bad = 0;
    pulses = 0;
    for (int n = 0; n <= FRAME_CLKS + 4; n++) begin
      int p, eh, ev;
      bit ehs, evs, evon, etick, efs;
      if (n > 0) @(negedge clk);
      p     = (n / CD) % (HT * VT);
      eh    = p % HT;
      ev    = p / HT;
      etick = (n % CD) == CD - 1;
      ehs   = !(eh >= HV + HFP && eh < HV + HFP + HS);
      evs   = !(ev >= VV + VFP && ev < VV + VFP + VS);
      evon  = (eh < HV) && (ev < VV);
      efs   = (n == FRAME_CLKS);
      if (frame_start) pulses++;
      if (h_count != 10'(eh) || v_count != 10'(ev) || hsync != ehs || vsync != evs ||
          video_on != evon || pix_tick != etick || frame_start != efs) bad++;
    end
    chk("sweep_errors", 32'(bad), 0);
    chk("sweep_frame_pulses", 32'(pulses), 1);

    // Normal update window: request in active video, done inside vblank.
    do_reset();
    wait_v(2, 400, "upd_wait_v2");
    upd_req = 1'b1;
    @(negedge clk);
    chk("upd_state_wait", 32'(dut.state), 32'(ST_WAIT_VBL));
    wait_v(8, 1000, "upd_wait_v8");
    chk("upd_grant_not_yet", 32'(upd_grant), 0);
    @(negedge clk);
    chk("upd_grant_rise", 32'(upd_grant), 1);
    wait_v(9, 400, "upd_wait_v9");
    upd_done = 1'b1;
    @(negedge clk);
    upd_done = 1'b0;
    chk("upd_grant_fall_done", 32'(upd_grant), 0);
    @(negedge clk);
    chk("upd_state_release", 32'(dut.state), 32'(ST_RELEASE));
    upd_req = 1'b0;
    @(negedge clk);
    chk("upd_state_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("upd_no_overrun", 32'(upd_overrun), 0);

    // Request withdrawn while waiting for vblank.
    do_reset();
    upd_req = 1'b1;
    @(negedge clk);
    chk("drop_state_wait", 32'(dut.state), 32'(ST_WAIT_VBL));
    upd_req = 1'b0;
    @(negedge clk);
    chk("drop_state_idle", 32'(dut.state), 32'(ST_IDLE));

    // upd_done outside GRANT ignored; done coincident with vblank end is not an overrun.
    do_reset();
    upd_req = 1'b1;
    wait_v(2, 400, "sim_wait_v2");
    upd_done = 1'b1;
    @(negedge clk);
    upd_done = 1'b0;
    wait_v(8, 1000, "sim_wait_v8");
    @(negedge clk);
    chk("sim_grant_open", 32'(upd_grant), 1);
    k = 0;
    while (!(v_count == 10'(VT - 1) && h_count == 10'(HT - 1) && pix_tick) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("sim_reach_last", 32'(k < 2000), 1);
    upd_done = 1'b1;
    @(negedge clk);
    upd_done = 1'b0;
    chk("sim_v_wrapped", 32'(v_count), 0);
    chk("sim_grant_closed", 32'(upd_grant), 0);
    chk("sim_no_overrun", 32'(upd_overrun), 0);
    chk("sim_state_release", 32'(dut.state), 32'(ST_RELEASE));

    // Overrun: request held, no done; grant revoked at wrap and reopened next vblank.
    do_reset();
    upd_req = 1'b1;
    wait_v(8, 1000, "ovr_wait_v8");
    @(negedge clk);
    chk("ovr_grant_open", 32'(upd_grant), 1);
    wait_v(0, 2000, "ovr_wait_v0");
    chk("ovr_grant_revoked", 32'(upd_grant), 0);
    chk("ovr_flag_set", 32'(upd_overrun), 1);
    chk("ovr_state_wait", 32'(dut.state), 32'(ST_WAIT_VBL));
    wait_v(8, 1000, "ovr_wait_v8_again");
    chk("ovr_grant_not_yet", 32'(upd_grant), 0);
    @(negedge clk);
    chk("ovr_grant_reopen", 32'(upd_grant), 1);
    chk("ovr_flag_sticky", 32'(upd_overrun), 1);

    // Asynchronous reset while the grant is open.
    #2 reset = 1'b1;
    #1;
    chk("areset_grant", 32'(upd_grant), 0);
    chk("areset_overrun", 32'(upd_overrun), 0);
    chk("areset_h", 32'(h_count), 0);
    chk("areset_v", 32'(v_count), 0);
    chk("areset_frame_cnt", 32'(frame_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    upd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("resume_tick", 32'(pix_tick), 1);
    @(negedge clk);
    chk("resume_h", 32'(h_count), 1);
    chk("resume_tick_low", 32'(pix_tick), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
